// File: rtl/latch_hold_bank.sv
// -----------------------------------------------------------------------------
// latch_hold_bank
//
// A bank of CHANNELS independent WIDTH-bit capture registers. Each channel gives
// latch-like behaviour from ordinary flops. While its gate is active, the
// channel follows D one edge late. When the gate goes inactive, the channel
// holds its value. VALID rises once the held value has stayed unchanged for
// HOLD cycles. A shared synchronous PRE loads PRE_VAL into every channel and
// marks it valid on the next edge.
//
// Ports
//   C          in   1                rising-edge clock
//   CLR_N      in   1                asynchronous reset, active low
//   G          in   CHANNELS         per-channel gate (polarity: GATE_ACT_LOW)
//   PRE        in   1                synchronous preset, all channels
//   D          in   CHANNELS*WIDTH   data, channel i = D[i*WIDTH +: WIDTH]
//   Q          out  CHANNELS*WIDTH   held/tracked data, same packing as D
//   VALID      out  CHANNELS         channel i locked and stable
//   ALL_VALID  out  1                AND of VALID
//   STATE_DBG  out  2*CHANNELS       per-channel FSM state, channel i at
//                                    STATE_DBG[2*i +: 2]
//                                    (0 IDLE, 1 OPEN, 2 SETTLE, 3 LOCKED)
//
// Handshake: none. G, D and PRE are level inputs sampled on every rising
// edge of C. There is no valid/ready pairing. VALID is a status output and
// carries no back-pressure.
// -----------------------------------------------------------------------------
module latch_hold_bank #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      CHANNELS     = 2,
  parameter int unsigned      HOLD         = 8,
  parameter logic [WIDTH-1:0] PRE_VAL      = 4'hF,
  parameter bit               GATE_ACT_LOW = 1'b1
) (
  input  logic                      C,
  input  logic                      CLR_N,
  input  logic [CHANNELS-1:0]       G,
  input  logic                      PRE,
  input  logic [CHANNELS*WIDTH-1:0] D,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       VALID,
  output logic                      ALL_VALID,
  output logic [2*CHANNELS-1:0]     STATE_DBG
);

  // The counter must be able to hold HOLD-1. It is kept at least one bit
  // wide so that the HOLD=0 build still elaborates cleanly.
  localparam int unsigned CNT_W = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

  // This is the value loaded on the first inactive edge. Including that edge,
  // the total settle time is HOLD edges.
  localparam logic [CNT_W-1:0] CNT_LOAD = (HOLD == 0) ? '0 : CNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_ch;
    logic             act;

    assign d_ch = D[ch*WIDTH +: WIDTH];
    // The gate is active when G differs from the inactive level.
    assign act  = G[ch] ^ GATE_ACT_LOW;

    always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        q_q     <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        q_q     <= q_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;

      if (PRE) begin
        // The preset wins over the gate on the same edge.
        q_d     = PRE_VAL;
        state_d = ST_LOCKED;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (act) begin
              q_d     = d_ch;
              state_d = ST_OPEN;
            end
          end

          ST_OPEN: begin
            if (act) begin
              q_d = d_ch;
            end else if (HOLD == 0) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_SETTLE;
              cnt_d   = CNT_LOAD;
            end
          end

          ST_SETTLE: begin
            if (act) begin
              // Re-opening abandons the settle. It restarts from scratch on
              // the next release.
              q_d     = d_ch;
              state_d = ST_OPEN;
              cnt_d   = '0;
            end else if (cnt_q == '0) begin
              state_d = ST_LOCKED;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end

          ST_LOCKED: begin
            if (act) begin
              q_d     = d_ch;
              state_d = ST_OPEN;
            end
          end

          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign Q[ch*WIDTH +: WIDTH] = q_q;
    assign VALID[ch]            = (state_q == ST_LOCKED);
    assign STATE_DBG[2*ch +: 2] = state_q;
  end

  // This is a pure decode of registered state, so it adds no latency.
  assign ALL_VALID = &VALID;

endmodule

// File: tb/tb_latch_hold_bank.sv
// -----------------------------------------------------------------------------
// tb_latch_hold_bank
//
// Three builds of latch_hold_bank share one set of stimulus:
//   dut0: HOLD=8, gate active low   (default build)
//   dut1: HOLD=0, gate active low
//   dut2: HOLD=3, gate active high
//
// The reference model tracks each channel by its last captured value and by
// how many consecutive edges have passed without gate activity. VALID follows
// from that run length, or from an undisturbed preset.
// -----------------------------------------------------------------------------
module tb_latch_hold_bank;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int ND = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]   g;
  logic           pre;
  logic [N*W-1:0] d;

  logic [N*W-1:0] q0, q1, q2;
  logic [N-1:0]   v0, v1, v2;
  logic           av0, av1, av2;
  logic [2*N-1:0] sd0, sd1, sd2;

  latch_hold_bank #(.WIDTH(W), .CHANNELS(N), .HOLD(8), .PRE_VAL(4'hF), .GATE_ACT_LOW(1'b1)) dut0 (
    .C(clk), .CLR_N(rst_n), .G(g), .PRE(pre), .D(d),
    .Q(q0), .VALID(v0), .ALL_VALID(av0), .STATE_DBG(sd0)
  );

  latch_hold_bank #(.WIDTH(W), .CHANNELS(N), .HOLD(0), .PRE_VAL(4'hF), .GATE_ACT_LOW(1'b1)) dut1 (
    .C(clk), .CLR_N(rst_n), .G(g), .PRE(pre), .D(d),
    .Q(q1), .VALID(v1), .ALL_VALID(av1), .STATE_DBG(sd1)
  );

  latch_hold_bank #(.WIDTH(W), .CHANNELS(N), .HOLD(3), .PRE_VAL(4'hF), .GATE_ACT_LOW(1'b0)) dut2 (
    .C(clk), .CLR_N(rst_n), .G(g), .PRE(pre), .D(d),
    .Q(q2), .VALID(v2), .ALL_VALID(av2), .STATE_DBG(sd2)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] m_q     [ND][N];
  int           m_quiet [ND][N];
  bit           m_ever  [ND][N];
  bit           m_pre   [ND][N];

  function automatic int hold_of(input int k);
    case (k)
      0:       return 8;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit act_low_of(input int k);
    return (k != 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < N; c++) begin
        m_q[k][c]     = '0;
        m_quiet[k][c] = 0;
        m_ever[k][c]  = 1'b0;
        m_pre[k][c]   = 1'b0;
      end
    end
  endtask

  // Call this once per rising edge, using the inputs the DUT sampled.
  task automatic model_step();
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < N; c++) begin
        bit a;
        a = act_low_of(k) ? ~g[c] : g[c];
        if (pre) begin
          m_q[k][c]     = 4'hF;
          m_pre[k][c]   = 1'b1;
          m_ever[k][c]  = 1'b0;
          m_quiet[k][c] = 0;
        end else if (a) begin
          m_q[k][c]     = d[c*W +: W];
          m_pre[k][c]   = 1'b0;
          m_ever[k][c]  = 1'b1;
          m_quiet[k][c] = 0;
        end else if (m_quiet[k][c] < 1000) begin
          m_quiet[k][c]++;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_q(input int k);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[c*W +: W] = m_q[k][c];
    return r;
  endfunction

  // A channel is valid after an undisturbed preset, or once it has seen more
  // than HOLD quiet edges since it last tracked D.
  function automatic logic [7:0] exp_v(input int k);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < N; c++)
      r[c] = m_pre[k][c] | (m_ever[k][c] & (m_quiet[k][c] > hold_of(k)));
    return r;
  endfunction

  function automatic logic [7:0] dut_q(input int k);
    case (k)
      0:       return q0;
      1:       return q1;
      default: return q2;
    endcase
  endfunction

  function automatic logic [7:0] dut_v(input int k);
    case (k)
      0:       return 8'(v0);
      1:       return 8'(v1);
      default: return 8'(v2);
    endcase
  endfunction

  function automatic logic [7:0] dut_av(input int k);
    case (k)
      0:       return 8'(av0);
      1:       return 8'(av1);
      default: return 8'(av2);
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < ND; k++) begin
        logic [7:0] ev;
        ev = exp_v(k);
        chk($sformatf("model_q%0d", k), dut_q(k), exp_q(k));
        chk($sformatf("model_valid%0d", k), dut_v(k), ev);
        chk($sformatf("model_all_valid%0d", k), dut_av(k), 8'(&ev[N-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are applied away from the clock edges. The model advances at the
  // same rising edge the DUT samples.
  task automatic step(input logic [N-1:0] gv, input logic [N*W-1:0] dv, input logic pv);
    g   = gv;
    d   = dv;
    pre = pv;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0] gr;

  initial begin
    rst_n = 1'b0;
    g     = '1;
    d     = '0;
    pre   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    chk("reset_q0", q0, 8'h00);
    chk("reset_valid0", 8'(v0), 8'h00);
    chk("reset_all_valid0", 8'(av0), 8'h00);
    chk("reset_q2", q2, 8'h00);

    #2;
    rst_n  = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Polarity and HOLD=0 builds, starting from fresh reset.
    step(2'b00, 8'h12, 1'b0);
    chk("lo_track_q0", q0, 8'h12);
    chk("lo_track_q1", q1, 8'h12);
    chk("hi_hold_q2", q2, 8'h00);
    chk("hi_idle_valid2", 8'(v2), 8'h00);
    step(2'b01, 8'h37, 1'b0);
    chk("mixed_q0", q0, 8'h32);
    chk("hold0_valid0", 8'(v0), 8'h00);
    chk("hold0_valid1", 8'(v1), 8'h01);
    chk("hi_track_q2", q2, 8'h07);

    // Track then settle on channel 0. Channel 1 stays idle.
    do_reset();
    step(2'b10, 8'h03, 1'b0);
    chk("track3_q0", q0, 8'h03);
    step(2'b10, 8'h05, 1'b0);
    chk("track5_q0", q0, 8'h05);
    step(2'b10, 8'h09, 1'b0);
    chk("track9_q0", q0, 8'h09);
    step(2'b11, 8'h0C, 1'b0);
    chk("release_q0", q0, 8'h09);
    chk("release_valid0", 8'(v0), 8'h00);
    for (int i = 0; i < 7; i++) step(2'b11, 8'($urandom), 1'b0);
    chk("settle7_valid0", 8'(v0), 8'h00);
    step(2'b11, 8'hA6, 1'b0);
    chk("settle8_valid0", 8'(v0), 8'h01);
    chk("settle8_all_valid0", 8'(av0), 8'h00);
    chk("settle8_q0", q0, 8'h09);

    // Glitch during settle: the re-open restarts the full settle.
    step(2'b10, 8'h06, 1'b0);
    step(2'b11, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 8'($urandom), 1'b0);
    step(2'b10, 8'h0A, 1'b0);
    chk("glitch_q0", q0, 8'h0A);
    chk("glitch_valid0", 8'(v0), 8'h00);
    step(2'b11, 8'h01, 1'b0);
    for (int i = 0; i < 7; i++) step(2'b11, 8'($urandom), 1'b0);
    chk("resettle7_valid0", 8'(v0), 8'h00);
    step(2'b11, 8'h01, 1'b0);
    chk("resettle8_valid0", 8'(v0), 8'h01);

    // Preset beats an active gate.
    step(2'b10, 8'h02, 1'b1);
    chk("preset_q0", q0, 8'hFF);
    chk("preset_valid0", 8'(v0), 8'h03);
    chk("preset_all_valid0", 8'(av0), 8'h01);
    step(2'b11, 8'h55, 1'b0);
    chk("preset_hold_q0", q0, 8'hFF);
    chk("preset_hold_valid0", 8'(v0), 8'h03);

    // Asynchronous reset in the middle of a settle.
    step(2'b10, 8'h04, 1'b0);
    step(2'b11, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_clr_q0", q0, 8'h00);
    chk("async_clr_valid0", 8'(v0), 8'h00);
    chk("async_clr_all_valid0", 8'(av0), 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Randomized phase. Gates are sticky so that settles can complete.
    gr = 2'b11;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) gr[b] = ~gr[b];
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
      end
      step(gr, 8'($urandom), ($urandom_range(0, 39) == 0));
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
